gray_rx_decoder: RTL

GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

---
 rtl/gray_pkg.sv | 6 +
 rtl/gray2bin.sv | 13 +
 rtl/gray_rx_decoder.sv | 97 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared defaults and tracking-state encoding for the Gray receive path.
package gray_pkg;
  localparam int GRAY_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  typedef enum logic {FIRST, TRACK} trk_state_e;
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decode.
//   gray : Gray-coded input word
//   bin  : binary word, bin[i] = xor of gray[WIDTH-1:i]
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: registered Gray-to-binary decoder with optional single-step adjacency checking.
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready/in_gray : upstream Gray word handshake
//   out_valid/out_ready/out_bin/out_adj_err : downstream decoded word handshake
//   resync, err_clr, err_cnt : checker controls and saturating error count
//   Macro GRAY_ADJ_CHECK_EN enables the adjacency checker and error counter.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_adj_err,
  input  logic             resync,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);
  logic             acc;
  logic             adj_err;
  logic [WIDTH-1:0] dec_bin;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             adj_q, adj_d;

  gray2bin #(.WIDTH(WIDTH)) u_dec (.gray(in_gray), .bin(dec_bin));

  assign in_ready    = !valid_q || out_ready;
  assign acc         = in_valid && in_ready;
  assign out_valid   = valid_q;
  assign out_bin     = bin_q;
  assign out_adj_err = adj_q;

  always_comb begin
    valid_d = acc ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    bin_d   = acc ? dec_bin : bin_q;
    adj_d   = acc ? adj_err : adj_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      adj_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
      adj_q   <= adj_d;
    end
  end

`ifdef GRAY_ADJ_CHECK_EN
  trk_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff;
  logic             multi;

  assign diff    = in_gray ^ prev_gray_q;
  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign multi   = |(diff & (diff - WIDTH'(1)));
  // Resync takes effect before the check, so a word accepted with it is never flagged.
  assign adj_err = acc && (state_q == TRACK) && !resync && multi;
  assign err_cnt = cnt_q;

  always_comb begin
    state_d     = acc ? TRACK : (resync ? FIRST : state_q);
    prev_gray_d = acc ? in_gray : prev_gray_q;
    cnt_d       = err_clr ? {{(CNT_W-1){1'b0}}, adj_err}
                : (adj_err && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FIRST;
      prev_gray_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= prev_gray_d;
      cnt_q       <= cnt_d;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = resync | err_clr;
  assign adj_err    = 1'b0;
  assign err_cnt    = '0;
`endif
endmodule
